// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port data memory.
// The master side is the requester/memory environment; the slave side is the arbiter.
interface data_mem_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic [1:0]            req_i;
  logic [1:0]            we_i;
  logic [ADDR_WIDTH-1:0] addr0_i;
  logic [ADDR_WIDTH-1:0] addr1_i;
  logic [DATA_WIDTH-1:0] wdata0_i;
  logic [DATA_WIDTH-1:0] wdata1_i;
  logic [1:0]            done_o;
  logic [DATA_WIDTH-1:0] rdata_o;
  logic                  core_stall_o;
  logic                  mem_en_o;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  modport master (
    output req_i, we_i, addr0_i, addr1_i, wdata0_i, wdata1_i, mem_rdata_i,
    input  done_o, rdata_o, core_stall_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport slave (
    input  req_i, we_i, addr0_i, addr1_i, wdata0_i, wdata1_i, mem_rdata_i,
    output done_o, rdata_o, core_stall_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the core (port 0)
// and the loader (port 1); each access holds the memory for MEM_LATENCY busy cycles.
module data_mem_arbiter #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned MEM_LATENCY = 2
) (
  input logic               clk,
  input logic               reset,
  data_mem_arbiter_if.slave bus
);

  localparam int unsigned     CNT_W    = 4;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic                  owner;
  logic                  last_grant;
  logic [1:0]            done_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  en_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  grant_c;

  // A single requester always wins; on a tie the port that did not go last wins.
  always_comb begin
    grant_c = bus.req_i[1];
    if (bus.req_i == 2'b11) grant_c = ~last_grant;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      done_q     <= 2'b00;
      rdata_q    <= '0;
      en_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      done_q <= 2'b00;
      unique case (state)
        IDLE: begin
          if (|bus.req_i) begin
            owner      <= grant_c;
            last_grant <= grant_c;
            addr_q     <= grant_c ? bus.addr1_i  : bus.addr0_i;
            wdata_q    <= grant_c ? bus.wdata1_i : bus.wdata0_i;
            we_q       <= bus.we_i[grant_c];
            en_q       <= 1'b1;
            cnt        <= '0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt + CNT_W'(1);
          // Last wait state: the memory read data is valid on this edge.
          if (cnt == LAST_CNT) begin
            if (!we_q) rdata_q <= bus.mem_rdata_i;
            done_q[owner] <= 1'b1;
            en_q          <= 1'b0;
            we_q          <= 1'b0;
            state         <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.done_o       = done_q;
  assign bus.rdata_o      = rdata_q;
  assign bus.mem_en_o     = en_q;
  assign bus.mem_we_o     = we_q;
  assign bus.mem_addr_o   = addr_q;
  assign bus.mem_wdata_o  = wdata_q;
  assign bus.core_stall_o = bus.req_i[0] & ~done_q[0];

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed and randomised bench for data_mem_arbiter: a latency-2 instance for the
// cycle-exact vectors and a latency-1 instance against a behavioural memory.
module tb_data_mem_arbiter;

  logic clk;
  logic reset;
  int   pass_cnt = 0;
  int   tot_cnt  = 0;

  data_mem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus0 ();
  data_mem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus1 ();

  data_mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LATENCY(2)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );
  data_mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Port drivers for the latency-1 instance, one element per requester process.
  logic        s_req   [2];
  logic        s_we    [2];
  logic [31:0] s_addr  [2];
  logic [31:0] s_wdata [2];
  assign bus1.req_i    = {s_req[1], s_req[0]};
  assign bus1.we_i     = {s_we[1], s_we[0]};
  assign bus1.addr0_i  = s_addr[0];
  assign bus1.addr1_i  = s_addr[1];
  assign bus1.wdata0_i = s_wdata[0];
  assign bus1.wdata1_i = s_wdata[1];

  // Behavioural 16-word memory behind the latency-1 instance.
  logic [31:0] ram [16];
  assign bus1.mem_rdata_i = ram[bus1.mem_addr_o[5:2]];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) ram[i] <= 32'(i) * 32'h0101_0101;
    end else if (bus1.mem_en_o && bus1.mem_we_o) begin
      ram[bus1.mem_addr_o[5:2]] <= bus1.mem_wdata_o;
    end
  end

  logic [31:0] ref_mem [16];
  int dcnt0 = 0;
  int dcnt1 = 0;
  always @(negedge clk) begin
    if (bus1.done_o[0]) dcnt0++;
    if (bus1.done_o[1]) dcnt1++;
  end

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] mrd;
    logic [1:0]  done;
    logic        stall;
    logic        en;
    logic        mwe;
    logic [31:0] maddr;
    logic [31:0] mwd;
    logic [31:0] rd;
  } vec_t;

  vec_t tv [15];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic drive0(input logic [1:0] req, input logic [1:0] we, input logic [31:0] a0,
                        input logic [31:0] a1, input logic [31:0] w0, input logic [31:0] w1,
                        input logic [31:0] mrd);
    bus0.req_i       = req;
    bus0.we_i        = we;
    bus0.addr0_i     = a0;
    bus0.addr1_i     = a1;
    bus0.wdata0_i    = w0;
    bus0.wdata1_i    = w1;
    bus0.mem_rdata_i = mrd;
  endtask

  task automatic do_reset();
    drive0(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic run_port(input int p);
    logic        w;
    logic [3:0]  idx;
    logic [31:0] d;
    int          gap;
    int          waited;
    bit          got;
    for (int k = 0; k < 25; k++) begin
      w   = 1'($urandom_range(0, 1));
      idx = 4'($urandom_range(0, 15));
      d   = $urandom;
      gap = $urandom_range(0, 3);
      repeat (gap) @(posedge clk);
      #1;
      s_req[p] = 1'b1; s_we[p] = w; s_addr[p] = {26'd0, idx, 2'b00}; s_wdata[p] = d;
      waited = 0; got = 1'b0;
      while (!got && waited < 20) begin
        @(negedge clk);
        if (bus1.done_o[p]) got = 1'b1;
        else waited++;
      end
      if (!got) begin
        tot_cnt++;
        $display("FAIL sweep_timeout port%0d txn%0d: no done within 20 cycles", p, k);
      end else if (!w) begin
        chk($sformatf("sweep_rd p%0d t%0d", p, k), 128'(bus1.rdata_o), 128'(ref_mem[idx]));
      end else begin
        ref_mem[idx] = d;
      end
      @(posedge clk);
      #1 s_req[p] = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, b1;
    logic [1:0] r;
    for (int p = 0; p < 2; p++) begin
      s_req[p] = 1'b0; s_we[p] = 1'b0; s_addr[p] = '0; s_wdata[p] = '0;
    end

    //             req    we     a0     a1     w0  w1            mrd            done  st    en    mwe   maddr  mwd           rd
    tv[0]  = '{2'b01, 2'b00, 32'h10, 32'h0,  0, 0,            32'hDEADBEEF, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0,        32'h0};
    tv[1]  = '{2'b01, 2'b00, 32'h10, 32'h0,  0, 0,            32'hDEADBEEF, 2'b00, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0,        32'h0};
    tv[2]  = '{2'b01, 2'b00, 32'h10, 32'h0,  0, 0,            32'hDEADBEEF, 2'b00, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0,        32'h0};
    tv[3]  = '{2'b01, 2'b00, 32'h10, 32'h0,  0, 0,            32'hDEADBEEF, 2'b01, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF};
    tv[4]  = '{2'b00, 2'b00, 32'h10, 32'h0,  0, 0,            32'hDEADBEEF, 2'b00, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF};
    tv[5]  = '{2'b10, 2'b10, 32'h10, 32'h20, 0, 32'h12345678, 32'hCAFEF00D, 2'b00, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF};
    tv[6]  = '{2'b10, 2'b10, 32'h10, 32'h20, 0, 32'h12345678, 32'hCAFEF00D, 2'b00, 1'b0, 1'b1, 1'b1, 32'h20, 32'h12345678, 32'hDEADBEEF};
    tv[7]  = '{2'b10, 2'b10, 32'h10, 32'h20, 0, 32'h12345678, 32'hCAFEF00D, 2'b00, 1'b0, 1'b1, 1'b1, 32'h20, 32'h12345678, 32'hDEADBEEF};
    tv[8]  = '{2'b10, 2'b10, 32'h10, 32'h20, 0, 32'h12345678, 32'hCAFEF00D, 2'b10, 1'b0, 1'b0, 1'b0, 32'h20, 32'h12345678, 32'hDEADBEEF};
    tv[9]  = '{2'b00, 2'b00, 32'h10, 32'h20, 0, 32'h12345678, 32'hCAFEF00D, 2'b00, 1'b0, 1'b0, 1'b0, 32'h20, 32'h12345678, 32'hDEADBEEF};
    tv[10] = '{2'b01, 2'b00, 32'h44, 32'h20, 0, 0,            32'h0BADF00D, 2'b00, 1'b1, 1'b0, 1'b0, 32'h20, 32'h12345678, 32'hDEADBEEF};
    tv[11] = '{2'b00, 2'b00, 32'h99, 32'h20, 0, 0,            32'h0BADF00D, 2'b00, 1'b0, 1'b1, 1'b0, 32'h44, 32'h0,        32'hDEADBEEF};
    tv[12] = '{2'b00, 2'b00, 32'h99, 32'h20, 0, 0,            32'h0BADF00D, 2'b00, 1'b0, 1'b1, 1'b0, 32'h44, 32'h0,        32'hDEADBEEF};
    tv[13] = '{2'b00, 2'b00, 32'h99, 32'h20, 0, 0,            32'h0BADF00D, 2'b01, 1'b0, 1'b0, 1'b0, 32'h44, 32'h0,        32'h0BADF00D};
    tv[14] = '{2'b00, 2'b00, 32'h99, 32'h20, 0, 0,            32'h0BADF00D, 2'b00, 1'b0, 1'b0, 1'b0, 32'h44, 32'h0,        32'h0BADF00D};

    drive0(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", 128'({bus0.done_o, bus0.rdata_o, bus0.mem_en_o, bus0.mem_we_o,
                             bus0.mem_addr_o, bus0.mem_wdata_o}), 128'(0));
    @(posedge clk);
    #1 reset = 1'b0;

    // Cycle-by-cycle vectors: core read, loader write, core read with request dropped mid-access.
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1 drive0(tv[i].req, tv[i].we, tv[i].a0, tv[i].a1, tv[i].w0, tv[i].w1, tv[i].mrd);
      @(negedge clk);
      chk($sformatf("vec%0d", i),
          128'({bus0.done_o, bus0.core_stall_o, bus0.mem_en_o, bus0.mem_we_o,
                bus0.mem_addr_o, bus0.mem_wdata_o, bus0.rdata_o}),
          128'({tv[i].done, tv[i].stall, tv[i].en, tv[i].mwe, tv[i].maddr, tv[i].mwd, tv[i].rd}));
    end

    // Both ports requesting continuously: grants alternate, one done every 4 cycles.
    do_reset();
    drive0(2'b11, 2'b10, 32'h100, 32'h200, 32'h0, 32'h11110000, 32'h0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      r = 2'b00;
      if (c % 4 == 3) r = ((c / 4) % 2 == 0) ? 2'b01 : 2'b10;
      chk($sformatf("alt_done c%0d", c), 128'(bus0.done_o), 128'(r));
      @(posedge clk);
      #1;
    end

    // Core arrives one cycle into a loader access and waits it out.
    do_reset();
    for (int c = 0; c < 9; c++) begin
      r = (c == 0) ? 2'b10 : (c <= 3) ? 2'b11 : (c <= 7) ? 2'b01 : 2'b00;
      drive0(r, 2'b00, 32'h80, 32'h30, 32'h0, 32'h0, 32'h5);
      @(negedge clk);
      chk($sformatf("wait_done c%0d", c), 128'(bus0.done_o),
          128'((c == 3) ? 2'b10 : (c == 7) ? 2'b01 : 2'b00));
      chk($sformatf("wait_stall c%0d", c), 128'(bus0.core_stall_o),
          128'((c >= 1 && c <= 6) ? 1'b1 : 1'b0));
      @(posedge clk);
      #1;
    end

    // Reset in the second busy cycle of a core write, then a tie that the core must win.
    do_reset();
    drive0(2'b01, 2'b01, 32'h50, 32'h0, 32'hA5A5A5A5, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 chk("rst_we_pre", 128'(bus0.mem_we_o), 128'(1'b1));
    #2 reset = 1'b1;
    drive0(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    #1 chk("rst_we_drop", 128'({bus0.mem_en_o, bus0.mem_we_o}), 128'(2'b00));
    @(negedge clk);
    #1 reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("rst_no_done c%0d", c), 128'({bus0.done_o, bus0.mem_en_o}), 128'(0));
    end
    @(posedge clk);
    #1 drive0(2'b11, 2'b00, 32'h60, 32'h70, 32'h0, 32'h0, 32'h600DCAFE);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 1) chk("post_rst_addr", 128'(bus0.mem_addr_o), 128'(32'h60));
      if (c == 3) chk("post_rst_done", 128'({bus0.done_o, bus0.rdata_o}), 128'({2'b01, 32'h600DCAFE}));
      @(posedge clk);
      #1;
    end
    drive0(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);

    // Latency-1 random sweep on both ports against a reference memory.
    do_reset();
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'(i) * 32'h0101_0101;
    b0 = dcnt0;
    b1 = dcnt1;
    fork
      run_port(0);
      run_port(1);
    join
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sweep_done_cnt0", 128'(dcnt0 - b0), 128'(25));
    chk("sweep_done_cnt1", 128'(dcnt1 - b1), 128'(25));

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
